// File: rtl/regfile_pkg.sv
// Shared types, default parameters and port-slice helper for the regfile_mp register store.
package regfile_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W_DEF   = 32;
  localparam int RF_ADDR_W_DEF   = 5;
  localparam int RF_NUM_RD_DEF   = 2;
  localparam int RF_ZERO_REG_DEF = 1;

  // Low bit of port 'port' inside a bus that packs one 'width'-bit field per port.
  function automatic int rf_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by reserve, cleared by either write port or by the init sweep.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     i_init_en,
  input  logic [ADDR_W-1:0]        i_init_addr,
  input  logic                     i_wr0_en,
  input  logic [ADDR_W-1:0]        i_wr0_addr,
  input  logic                     i_wr1_en,
  input  logic [ADDR_W-1:0]        i_wr1_addr,
  input  logic                     i_rsv_en,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  output logic [(2**ADDR_W)-1:0]   o_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Reserve beats a same-cycle write so a re-reserved destination stays pending.
  always_comb begin
    // NOTE: the default assignment before the loop keeps this block purely combinational (no latch).
    w_busy_nxt = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_init_en) begin
        if (i_init_addr == ADDR_W'(i)) w_busy_nxt[i] = 1'b0;
      end else if (i_rsv_en && (i_rsv_addr == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if ((i_wr0_en && (i_wr0_addr == ADDR_W'(i))) ||
                   (i_wr1_en && (i_wr1_addr == ADDR_W'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
  end

  // NOTE: no reset branch here; the init sweep clears every bit, and <= keeps all bits updating in parallel.
  always_ff @(posedge clk) begin
    r_busy <= w_busy_nxt;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with busy scoreboard and a one-entry-per-cycle clearing sequencer.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int ADDR_W   = RF_ADDR_W_DEF,
  parameter int NUM_RD   = RF_NUM_RD_DEF,
  parameter int ZERO_REG = RF_ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     ready
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_run;
  logic              w_init;
  logic              w_wr0_en;
  logic              w_wr1_en;
  logic              w_rsv_en;
  logic [DEPTH-1:0]  w_busy;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RF_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RF_INIT: if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = RF_RUN;
      RF_RUN:  w_state_nxt = RF_RUN;
      default: w_state_nxt = RF_INIT;
    endcase
  end

  always_comb begin
    w_run  = (r_state == RF_RUN);
    w_init = (r_state == RF_INIT);
    ready  = w_run;
  end

  always_ff @(posedge clk) begin
    if (rst)         r_cnt <= '0;
    else if (w_init) r_cnt <= r_cnt + ADDR_W'(1);
  end

  // Register 0 is hard-wired when ZERO_EN, so its writes and reserves never reach state.
  always_comb begin
    w_wr0_en = w_run && wr0_en && !(ZERO_EN && (wr0_addr == '0));
    w_wr1_en = w_run && wr1_en && !(ZERO_EN && (wr1_addr == '0));
    w_rsv_en = w_run && rsv_en && !(ZERO_EN && (rsv_addr == '0));
  end

  // NOTE: both writes are non-blocking to the same array; the later one (wr1) wins on an address collision.
  always_ff @(posedge clk) begin
    if (w_init) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_wr0_en) r_mem[wr0_addr] <= wr0_data;
      if (w_wr1_en) r_mem[wr1_addr] <= wr1_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk         (clk),
    .i_init_en   (w_init),
    .i_init_addr (r_cnt),
    .i_wr0_en    (w_wr0_en),
    .i_wr0_addr  (wr0_addr),
    .i_wr1_en    (w_wr1_en),
    .i_wr1_addr  (wr1_addr),
    .i_rsv_en    (w_rsv_en),
    .i_rsv_addr  (rsv_addr),
    .o_busy      (w_busy)
  );

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_addr = rd_addr[rf_lsb(gi, ADDR_W) +: ADDR_W];

    always_comb begin
      w_data = r_mem[w_addr];
      w_bsy  = w_busy[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr0_en && (wr0_addr == w_addr)) begin
        w_data = wr0_data;
        w_bsy  = w_rsv_en && (rsv_addr == w_addr);
      end
      if (w_wr1_en && (wr1_addr == w_addr)) begin
        w_data = wr1_data;
        w_bsy  = w_rsv_en && (rsv_addr == w_addr);
      end
`endif
      if ((ZERO_EN && (w_addr == '0)) || !w_run) begin
        w_data = '0;
        w_bsy  = 1'b0;
      end
    end

    assign rd_data[rf_lsb(gi, DATA_W) +: DATA_W] = w_data;
    assign rd_busy[gi] = w_bsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-driven bench for regfile_mp with four read ports; expectations come from a local register model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 4;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              wr0_en = 1'b0, wr1_en = 1'b0, rsv_en = 1'b0;
  logic [AW-1:0]     wr0_addr = '0, wr1_addr = '0, rsv_addr = '0;
  logic [DW-1:0]     wr0_data = '0, wr1_data = '0;
  logic              ready;

  typedef struct {
    int          port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] m_mem  [DEPTH];
  logic          m_busy [DEPTH];

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0; m_busy[i] = 1'b0;
    end
  endtask

  // Model of one write; 'keep_busy' marks a same-cycle reserve of that address.
  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep_busy);
    if (a != '0) begin
      m_mem[a]  = d;
      m_busy[a] = keep_busy;
    end
  endtask

  task automatic test_reset();
    int n, bad;
    exp_t e;
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    // Writes and reserves during INIT must be ignored.
    wr0_en = 1'b1; wr0_addr = 5'd2; wr0_data = 32'h0000_0BAD;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    rd_addr = {5'd31, 5'd7, 5'd3, 5'd2};
    n = 0; bad = 0;
    #1;
    while (ready !== 1'b1 && n < 100) begin
      if (rd_data !== '0 || rd_busy !== '0) bad++;
      n++;
      @(negedge clk); #1;
    end
    drive_idle();
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL init_latency: ready after %0d cycles, expected %0d", n, DEPTH);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL init_outputs: %0d cycles with nonzero rd_data/rd_busy, expected 0", bad);
    end
    model_clear();
    for (int a = 0; a < DEPTH; a++) exp_q.push_back('{a % NR, AW'(a), m_mem[a], m_busy[a], "init_clear"});
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      rd_addr[e.port*AW +: AW] = e.addr;
      #1; checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_reset_mid_init();
    int n, early;
    exp_t e;
    @(negedge clk); wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'hCAFE; rsv_en = 1'b1; rsv_addr = 5'd12;
    @(negedge clk); drive_idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    early = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready !== 1'b0) early++;
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n = 0;
    #1;
    while (ready !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL mid_init_ready: ready high in %0d early cycles, expected 0", early);
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL mid_init_latency: ready after %0d cycles, expected %0d", n, DEPTH);
    end
    model_clear();
    exp_q.push_back('{1, 5'd9, m_mem[9], m_busy[9], "mid_init_clear_data"});
    exp_q.push_back('{2, 5'd12, m_mem[12], m_busy[12], "mid_init_clear_busy"});
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      rd_addr[e.port*AW +: AW] = e.addr;
      #1; checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_write_collision();
    exp_t e;
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hAAAA;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h5555;
    @(negedge clk);
    wr1_en = 1'b0;
    wr0_addr = 5'd0; wr0_data = 32'h1234; rsv_en = 1'b1; rsv_addr = 5'd0;
    @(negedge clk); drive_idle();
    model_write(5'd5, 32'h5555, 1'b0);
    exp_q.push_back('{0, 5'd5, m_mem[5], m_busy[5], "collision_wr1_wins"});
    exp_q.push_back('{1, 5'd0, 32'h0, 1'b0, "zero_reg_write"});
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      rd_addr[e.port*AW +: AW] = e.addr;
      #1; checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    for (int step = 0; step < 4; step++) begin
      @(negedge clk);
      case (step)
        0: begin rsv_en = 1'b1; rsv_addr = 5'd7; m_busy[7] = 1'b1; end
        1: begin wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h99; model_write(5'd7, 32'h99, 1'b0); end
        2: begin
             rsv_en = 1'b1; rsv_addr = 5'd7; wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h77;
             model_write(5'd7, 32'h77, 1'b1);
           end
        default: begin
             rsv_en = 1'b1; rsv_addr = 5'd8; wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h78;
             model_write(5'd7, 32'h78, 1'b0); m_busy[8] = 1'b1;
           end
      endcase
      exp_q.push_back('{2, 5'd7, m_mem[7], m_busy[7], $sformatf("scoreboard_step%0d", step)});
      if (step == 3) exp_q.push_back('{3, 5'd8, m_mem[8], m_busy[8], "scoreboard_other_rsv"});
      @(negedge clk); drive_idle();
      while (exp_q.size() > 0) begin
        @(negedge clk);
        e = exp_q.pop_front();
        rd_addr[e.port*AW +: AW] = e.addr;
        #1; checks++;
        if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    @(negedge clk); wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h1111;
    @(negedge clk); drive_idle(); model_write(5'd3, 32'h1111, 1'b0);
    for (int step = 0; step < 4; step++) begin
      @(negedge clk);
      drive_idle();
      case (step)
        0: begin
             wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hDEAD;
             wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hFFFF;
             rd_addr[0*AW +: AW] = 5'd3;
`ifdef REGFILE_BYPASS_EN
             exp_q.push_back('{0, 5'd3, 32'hDEAD, 1'b0, "bypass_same_cycle"});
`else
             exp_q.push_back('{0, 5'd3, m_mem[3], m_busy[3], "no_bypass_old_value"});
`endif
             model_write(5'd3, 32'hDEAD, 1'b0);
           end
        1: exp_q.push_back('{0, 5'd3, m_mem[3], m_busy[3], "bypass_committed"});
        2: begin
             wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'hBEEF; rsv_en = 1'b1; rsv_addr = 5'd4;
`ifdef REGFILE_BYPASS_EN
             exp_q.push_back('{1, 5'd4, 32'hBEEF, 1'b1, "bypass_with_rsv"});
`else
             exp_q.push_back('{1, 5'd4, m_mem[4], m_busy[4], "no_bypass_with_rsv"});
`endif
             model_write(5'd4, 32'hBEEF, 1'b1);
           end
        default: exp_q.push_back('{1, 5'd4, m_mem[4], m_busy[4], "rsv_write_committed"});
      endcase
      e = exp_q.pop_front();
      rd_addr[e.port*AW +: AW] = e.addr;
      #1; checks++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
      end
      if (step == 0) begin
        rd_addr[2*AW +: AW] = 5'd0;
        #1; checks++;
        if (rd_data[2*DW +: DW] !== 32'h0 || rd_busy[2] !== 1'b0) begin
          errors++;
          $display("FAIL zero_overrides_bypass: got data=%h busy=%b, expected data=0 busy=0",
                   rd_data[2*DW +: DW], rd_busy[2]);
        end
      end
    end
    @(negedge clk); drive_idle();
  endtask

  task automatic test_multiport();
    exp_t e;
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 32'h11;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 32'h22;
    @(negedge clk);
    wr0_addr = 5'd3; wr0_data = 32'h33;
    wr1_addr = 5'd4; wr1_data = 32'h44;
    @(negedge clk); drive_idle();
    model_write(5'd1, 32'h11, 1'b0); model_write(5'd2, 32'h22, 1'b0);
    model_write(5'd3, 32'h33, 1'b0); model_write(5'd4, 32'h44, 1'b0);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      for (int p = 0; p < NR; p++) begin
        logic [AW-1:0] a;
        a = (pass == 0) ? AW'(p + 1) : AW'(NR - p);
        rd_addr[p*AW +: AW] = a;
        exp_q.push_back('{p, a, m_mem[a], m_busy[a], $sformatf("multiport_pass%0d", pass)});
      end
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [AW-1:0] a, prev;
    logic [DW-1:0] d;
    prev = 5'd1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      drive_idle();
      rd_addr[3*AW +: AW] = prev;
      if (k < 20) begin
        do a = AW'($urandom_range(DEPTH - 1, 1)); while (a == prev);
        d = $urandom;
        if (k % 2 == 0) begin wr0_en = 1'b1; wr0_addr = a; wr0_data = d; end
        else            begin wr1_en = 1'b1; wr1_addr = a; wr1_data = d; end
      end
      #1;
      if (k > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rd_data[e.port*DW +: DW] !== e.data || rd_busy[e.port] !== e.busy) begin
          errors++;
          $display("FAIL %s port%0d addr%0d: got data=%h busy=%b, expected data=%h busy=%b",
                   e.name, e.port, e.addr, rd_data[e.port*DW +: DW], rd_busy[e.port], e.data, e.busy);
        end
      end
      if (k < 20) begin
        model_write(a, d, 1'b0);
        exp_q.push_back('{3, a, m_mem[a], m_busy[a], $sformatf("back_to_back_%0d", k)});
        prev = a;
      end
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_reset_mid_init();
    test_write_collision();
    test_scoreboard();
    test_bypass();
    test_multiport();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read, dual-write register file with a busy-bit scoreboard and a self-clearing reset sequencer. It is the datapath register store for the pipelined core: decode reads operands and reserves destinations, and writeback retires results. Storage is cleared one entry per cycle after reset, so no large reset fan-out is needed.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of combinational read ports (1..4)
- ZERO_REG, 1, when 1, entry 0 reads as zero, ignores writes and is never marked busy
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed in the same order
- rd_busy  out  NUM_RD  busy bit of each read address
- wr0_en, wr0_addr, wr0_data  in  1/ADDR_W/DATA_W  write port 0 (ALU writeback)
- wr1_en, wr1_addr, wr1_data  in  1/ADDR_W/DATA_W  write port 1 (load writeback)
- rsv_en, rsv_addr  in  1/ADDR_W  reserve a destination and set its busy bit
- ready  out  1  high once initialisation is complete

## Operation
- States are INIT and RUN.
- rst (any cycle, including mid-INIT) forces INIT with init counter = 0.
- INIT: each cycle writes mem[cnt] = 0 and busy[cnt] = 0, then cnt++. After clearing entry DEPTH-1, the next state is RUN.
- INIT: the wr*, rsv_en and rd_* inputs are ignored. rd_data = 0, rd_busy = 0, ready = 0.
- RUN: ready = 1. Reads are combinational: rd_data[i] = mem[rd_addr[i]] and rd_busy[i] = busy[rd_addr[i]].
- Writes commit on the clock edge.
- If wr0 and wr1 target the same address in the same cycle, wr1 wins for data.
- Any write to an address clears its busy bit.
- rsv_en sets busy[rsv_addr].
- If a reserve and a write hit the same address in the same cycle, the reserve wins: busy stays 1 and the data is still written.
- ZERO_REG=1, address 0: reads return 0, writes are dropped, reserve is dropped, and rd_busy = 0.
- Addresses are always in range, because DEPTH is a power of two.

## Timing
- Reset values: ready = 0, rd_data = 0, rd_busy = 0 from the cycle after rst is sampled high.
- INIT lasts exactly DEPTH cycles after rst deasserts. ready rises on the following edge (the first RUN cycle).
- Write to read latency is 1 cycle without bypass: data is visible the cycle after the write edge.
- Reserve to busy latency is 1 cycle.
- Busy clear by write: visible in the cycle after the write edge without bypass.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose address matches an active write in the same cycle returns the write data combinationally, with wr1 priority over wr0.
  - rd_busy for that address reads 0, unless rsv_en targets the same address in that cycle.
  - The ZERO_REG rule still overrides bypass.
- REGFILE_BYPASS_EN undefined: reads reflect only committed state, with the 1-cycle latency above.

## Structure
- Package regfile_pkg holds:
  - the state enum typedef (RF_INIT, RF_RUN)
  - default parameter constants
  - a function packing and unpacking per-port address slices
- Sub-module regfile_scoreboard holds the DEPTH busy bits. It handles set/clear priority and clear-on-init, and takes the two write ports and the reserve port.
- Storage, the init FSM and the read muxes stay in regfile_mp.

## Test plan
- **Init:** assert rst for 1 cycle, DEPTH=32.
  - ready = 0 for 32 cycles, then 1.
  - All 32 entries read 0 and not busy.
- **Reset mid-init:** pulse rst when cnt = 10.
  - The counter restarts, and ready rises 32 cycles after the second rst.
- **Write collision:** wr0 and wr1 both target addr 5 with 0xAAAA and 0x5555.
  - The next cycle, rd_data = 0x5555.
  - A wr0 to addr 0 with 0x1234 (ZERO_REG=1) still reads 0.
- **Scoreboard:**
  - rsv addr 7, then rd_busy = 1 next cycle.
  - wr1 addr 7 = 0x99, then rd_busy = 0 and data = 0x99.
  - rsv and wr on addr 7 in the same cycle leaves busy = 1.
- **Bypass (REGFILE_BYPASS_EN):** wr0 addr 3 = 0xDEAD while rd_addr[0] = 3.
  - rd_data[0] = 0xDEAD in the same cycle.
  - Without the macro, it reads the old value that cycle and 0xDEAD the next.
- **Multi-port:** NUM_RD=4, all ports read distinct addresses 1..4 preloaded 0x11..0x44.
  - Each port returns its own value, with no cross-port aliasing.
